// File: rtl/pll_reset_sequencer.sv
// Reset and lock sequencer for the board PLL: pulses the PLL reset, waits for a
// stable lock, then releases the outclk_0 and outclk_1 domain resets in order.
module pll_reset_sequencer #(
    parameter int CNT_W               = 20,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP         = 256,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       force_reset,
    output logic       pll_rst,
    output logic [1:0] rst_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_count,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL       = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
    localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       retry_s;
    logic [7:0]       loss_s;
    logic             lock_meta_r, lock_sync_r;
    logic             abort_s, lost_s;
    logic             pll_rst_s, ready_s, fail_s;
    logic [1:0]       rst_n_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Two-flop synchronizer for the asynchronous PLL lock output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // State, counter, status and decoded output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_PLL_RST;
            cnt_r       <= CNT_ZERO;
            retry_count <= 3'd0;
            loss_count  <= 8'd0;
            pll_rst     <= 1'b1;
            rst_n       <= 2'b00;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            retry_count <= retry_s;
            loss_count  <= loss_s;
            pll_rst     <= pll_rst_s;
            rst_n       <= rst_n_s;
            ready       <= ready_s;
            fail        <= fail_s;
        end
    end

    // Next-state logic; outputs decode from the state about to be entered.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        retry_s = retry_count;
        loss_s  = loss_count;
        abort_s = 1'b0;
        lost_s  = 1'b0;
        case (state_r)
            ST_PLL_RST: begin
                if (cnt_r == PLL_RST_LAST) begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_r) begin
                    state_s = ST_STABLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!lock_sync_r) begin
                    abort_s = 1'b1;
                end else if (cnt_r == STABLE_LAST) begin
                    state_s = ST_REL;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_REL: begin
                if (!lock_sync_r) begin
                    lost_s = 1'b1;
                end else if (cnt_r == GAP_LAST) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_sync_r) begin
                    lost_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FAIL: begin
                state_s = ST_FAIL;
            end
            default: begin
                state_s = ST_PLL_RST;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // force_reset overrides a same-cycle timeout or lock loss.
        if (force_reset) begin
            state_s = ST_PLL_RST;
            cnt_s   = CNT_ZERO;
            retry_s = 3'd0;
        end else if (abort_s) begin
            cnt_s = CNT_ZERO;
            if (retry_count == RETRY_LIMIT) begin
                state_s = ST_FAIL;
            end else begin
                state_s = ST_PLL_RST;
                retry_s = retry_count + 3'd1;
            end
        end else if (lost_s) begin
            state_s = ST_PLL_RST;
            cnt_s   = CNT_ZERO;
            retry_s = 3'd0;
            loss_s  = sat_inc8(loss_count);
        end else begin
            loss_s = loss_count;
        end

        pll_rst_s = (state_s == ST_PLL_RST) || (state_s == ST_FAIL);
        rst_n_s   = {state_s == ST_RUN, (state_s == ST_REL) || (state_s == ST_RUN)};
        ready_s   = (state_s == ST_RUN);
        fail_s    = (state_s == ST_FAIL);
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/force/reset
// traffic, every cycle compared against a phase/deadline reference model.
module tb_pll_reset_sequencer;

    localparam int PRC  = 4;
    localparam int LTC  = 32;
    localparam int LSC  = 8;
    localparam int GAP  = 4;
    localparam int MAXR = 2;

    // Model phases: reset pulse, seeking lock, settling, partial release, full run, dead.
    localparam int HOLD = 0, SEEK = 1, SETTLE = 2, PART = 3, FULL = 4, DEAD = 5;

    logic       clk = 1'b0;
    logic       reset_n, pll_locked, force_reset;
    logic       pll_rst, ready, fail;
    logic [1:0] rst_n;
    logic [2:0] retry_count;
    logic [7:0] loss_count;

    int n_vec = 0;
    int n_err = 0;
    int m_phase, m_left, m_retries, m_losses;
    bit hist[$];

    pll_reset_sequencer #(
        .CNT_W(20), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(LTC),
        .LOCK_STABLE_CYCLES(LSC), .RELEASE_GAP(GAP), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .force_reset(force_reset),
        .pll_rst(pll_rst), .rst_n(rst_n), .ready(ready), .fail(fail),
        .retry_count(retry_count), .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic restart_attempt();
        m_phase = HOLD;
        m_left  = PRC;
    endtask

    task automatic give_up();
        if (m_retries == MAXR) begin
            m_phase = DEAD;
        end else begin
            m_retries++;
            restart_attempt();
        end
    endtask

    task automatic lose();
        m_losses  = (m_losses < 255) ? m_losses + 1 : 255;
        m_retries = 0;
        restart_attempt();
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic model_step();
        bit ls;
        if (!reset_n) begin
            restart_attempt();
            m_retries = 0;
            m_losses  = 0;
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            return;
        end
        ls = hist[hist.size() - 2];
        hist.push_back(pll_locked);
        if (hist.size() > 3) void'(hist.pop_front());
        if (force_reset) begin
            m_retries = 0;
            restart_attempt();
            return;
        end
        case (m_phase)
            HOLD: begin
                m_left--;
                if (m_left == 0) begin m_phase = SEEK; m_left = LTC; end
            end
            SEEK: begin
                if (ls) begin
                    m_phase = SETTLE; m_left = LSC;
                end else begin
                    m_left--;
                    if (m_left == 0) give_up();
                end
            end
            SETTLE: begin
                if (!ls) give_up();
                else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PART; m_left = GAP; end
                end
            end
            PART: begin
                if (!ls) lose();
                else begin
                    m_left--;
                    if (m_left == 0) m_phase = FULL;
                end
            end
            FULL: if (!ls) lose();
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("pll_rst", {31'd0, pll_rst}, {31'd0, (m_phase == HOLD) || (m_phase == DEAD)});
        check_val("rst_n", {30'd0, rst_n},
                  {30'd0, m_phase == FULL, (m_phase == PART) || (m_phase == FULL)});
        check_val("ready", {31'd0, ready}, {31'd0, m_phase == FULL});
        check_val("fail", {31'd0, fail}, {31'd0, m_phase == DEAD});
        check_val("retry_count", {29'd0, retry_count}, m_retries);
        check_val("loss_count", {24'd0, loss_count}, m_losses);
        @(negedge clk);
    endtask

    task automatic run_until_ready(input int limit);
        int n = 0;
        while (!ready && n < limit) begin
            tick();
            n++;
        end
        check_val("ready_reached", {31'd0, ready}, 32'd1);
    endtask

    task automatic do_reset(input logic lock_lvl);
        reset_n    = 1'b0;
        pll_locked = lock_lvl;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int first0, firstr, lb, len;
        logic lvl;
        reset_n = 1'b0; pll_locked = 1'b1; force_reset = 1'b0;

        // Clean start: edge numbering starts at the first edge sampling reset_n=1.
        repeat (3) tick();
        reset_n = 1'b1;
        first0 = 0; firstr = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (rst_n[0] && first0 == 0) first0 = e;
            if (ready && firstr == 0) firstr = e;
        end
        check_val("rel0_edge", first0, 32'd13);
        check_val("ready_edge", firstr, 32'd17);

        // No lock: three timeouts lead to a sticky FAIL.
        do_reset(1'b0);
        repeat (3 * (PRC + LTC)) tick();
        check_val("fail_set", {31'd0, fail}, 32'd1);
        check_val("fail_retry", {29'd0, retry_count}, 32'd2);
        repeat (1000) tick();
        check_val("fail_sticky", {31'd0, fail}, 32'd1);
        check_val("fail_rst_n", {30'd0, rst_n}, 32'd0);

        // force_reset out of FAIL.
        pll_locked = 1'b1; force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        check_val("fr_fail_clr", {31'd0, fail}, 32'd0);
        check_val("fr_retry_clr", {29'd0, retry_count}, 32'd0);
        run_until_ready(40);

        // Late lock after the second timeout.
        do_reset(1'b0);
        repeat (2 * (PRC + LTC) + PRC) tick();
        pll_locked = 1'b1;
        run_until_ready(60);
        check_val("late_retry", {29'd0, retry_count}, 32'd2);

        // Repeated 1-cycle lock loss in RUN, saturating loss_count.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            tick();
            tick();
            check_val("loss_drop", {30'd0, rst_n, ready}, 32'd0);
            run_until_ready(60);
        end
        check_val("loss_sat", {24'd0, loss_count}, 32'd255);

        // One-cycle glitch while settling.
        do_reset(1'b1);
        repeat (6) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (4) tick();
        check_val("glitch_retry", {29'd0, retry_count}, 32'd1);
        check_val("glitch_pll_rst", {31'd0, pll_rst}, 32'd1);
        run_until_ready(60);

        // force_reset on the same edge as a lock loss in RUN.
        lb = m_losses;
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        check_val("fr_loss_keep", {24'd0, loss_count}, lb);
        check_val("fr_loss_pll_rst", {31'd0, pll_rst}, 32'd1);
        run_until_ready(60);

        // Random segments of lock level with sparse force_reset and reset_n.
        for (int c = 0; c < 4000; c += len) begin
            lvl = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 60);
            for (int k = 0; k < len; k++) begin
                pll_locked  = (k == len - 1 && $urandom_range(0, 3) == 0) ? ~lvl : lvl;
                force_reset = ($urandom_range(0, 199) == 0);
                reset_n     = ($urandom_range(0, 499) != 0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock sequencer for the board PLL. It runs on the free-running 50 MHz reference clock and drives the PLL reset input. It watches the PLL lock output and releases the downstream domain resets for outclk_0 (5 MHz) and outclk_1 (28 MHz) in a fixed order once lock is stable. It retries a PLL that fails to lock, re-sequences on lock loss and reports status for GPIO/debug.

## Interface
Parameters:
- CNT_W, 20, width of the shared cycle counter; every cycle parameter must be ≤ 2^CNT_W−1
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt
- LOCK_TIMEOUT_CYCLES, 500000, cycles allowed in WAIT_LOCK before a retry (10 ms at 50 MHz)
- LOCK_STABLE_CYCLES, 1024, cycles the synchronized lock must stay high before release
- RELEASE_GAP, 256, cycles between rst_n[0] release and rst_n[1] release
- MAX_RETRIES, 7, retries allowed before FAIL (3-bit range)

Ports:
- clk  in  1  free-running 50 MHz reference clock, same net as the PLL refclk
- reset_n  in  1  reset, synchronous, active-low
- pll_locked  in  1  PLL locked output, asynchronous to clk
- force_reset  in  1  synchronous request to restart the whole sequence
- pll_rst  out  1  reset to the PLL rst input, active-high
- rst_n  out  2  domain resets, active-low: bit0 for the outclk_0 domain, bit1 for the outclk_1 domain
- ready  out  1  all domains released and lock valid
- fail  out  1  retries exhausted
- retry_count  out  3  timeouts/dropouts in the current attempt series
- loss_count  out  8  lock losses after release, saturating

## Operation
- pll_locked passes through a 2-flop synchronizer to give lock_s. The synchronizer flops reset to 0.
- All outputs are registered and decoded from the state entered at the same edge:
  - pll_rst=1 in PLL_RST and FAIL
  - rst_n[0]=1 in REL and RUN
  - rst_n[1]=1 and ready=1 only in RUN
  - fail=1 only in FAIL
- States and transitions (cnt restarts at 0 on every state entry):
  - PLL_RST: leave after PLL_RST_CYCLES cycles → WAIT_LOCK.
  - WAIT_LOCK:
    - lock_s=1 → STABLE.
    - Timeout at LOCK_TIMEOUT_CYCLES cycles: if retry_count==MAX_RETRIES → FAIL; else retry_count+1 → PLL_RST.
  - STABLE:
    - lock_s=0 → handled exactly as a WAIT_LOCK timeout (retry or FAIL).
    - LOCK_STABLE_CYCLES consecutive cycles → REL.
  - REL: after RELEASE_GAP cycles → RUN.
  - RUN: terminal while lock holds.
  - Lock loss in REL or RUN (lock_s=0): rst_n=00 and ready=0 at the next edge; loss_count+1 (saturates at 255); retry_count←0; → PLL_RST.
  - FAIL: sticky. Exits only on reset_n=0 or force_reset.
- force_reset=1 in any state, including FAIL:
  - → PLL_RST; cnt, retry_count and fail clear.
  - loss_count is not cleared.
  - It takes priority over a simultaneous lock loss or timeout; loss_count and retry_count are not incremented that cycle.
- Counter width: cnt is CNT_W bits, unsigned, compared for equality against parameter−1, and never wraps in a legal configuration.

## Timing
- While reset_n=0 (sampled at an edge), at the next edge:
  - state=PLL_RST, cnt=0
  - pll_rst=1, rst_n=00, ready=0, fail=0
  - retry_count=0, loss_count=0, sync flops=0
- Reset mid-operation (any state): the same values at the next edge. rst_n drops within one cycle.
- Lock detection latency: 2 cycles (synchronizer) plus 1 cycle (state register).
- With pll_locked high throughout, ready rises PLL_RST_CYCLES+1+LOCK_STABLE_CYCLES+RELEASE_GAP edges after the first edge sampling reset_n=1.
- rst_n[0] rises exactly RELEASE_GAP edges before rst_n[1]. Both fall on the same edge.
- rst_n is synchronous to clk. Each consuming domain re-synchronizes deassertion in its own clock; that is outside this block.
- A lock_s glitch of 1 cycle in STABLE aborts the attempt. No filtering beyond the synchronizer.

## Test plan
Parameter set for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, RELEASE_GAP=4, MAX_RETRIES=2.
- Clean start: pll_locked=1 from time 0; release reset_n → pll_rst high 4 cycles, rst_n[0] rises at edge 13, rst_n[1] and ready at edge 17, fail=0, retry_count=0.
- No lock: pll_locked=0 forever → pll_rst pattern 4 high / 32 low repeated; retry_count 1 then 2; after the third timeout fail=1, pll_rst=1, rst_n=00, retry_count=2; it stays there for 1000 cycles.
- Late lock: pll_locked rises after the second timeout → ready asserts; retry_count=2 while in RUN.
- Lock loss in RUN: drop pll_locked for 1 cycle → rst_n=00 and ready=0 three edges later; loss_count=1; a full re-sequence completes. Repeat 300 times → loss_count saturates at 255.
- STABLE glitch: pll_locked 1-cycle low pulse during STABLE → retry_count+1, back to PLL_RST; rst_n never rose.
- force_reset: pulse while in FAIL, and separately on the same cycle as a lock loss in RUN → PLL_RST next edge, fail=0, retry_count=0; loss_count unchanged in the simultaneous case.
